mc_sequencer: RTL
=================

# mc_sequencer

Multicycle control sequencer that drives the datapath ALU: fetches 32-bit instructions over a request/valid port, reads operands from an internal 8×32 register file, and presents `alu_ip_0`/`alu_ip_1`/`alu_opcode` to the ALU. It consumes the ALU's `op_0` result and `change_pc` branch flag, then writes back results and updates the PC. It is the initiator side of the ALU interface and sits between instruction memory and the ALU in the multicycle CPU top level.

## Interface
- `PC_W`, 8, PC and `imem_addr` width in bits; PC is word-addressed.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request; high only in FETCH.
- `imem_addr`  out  PC_W  fetch address; equals PC.
- `imem_valid`  in  1  instruction data valid; sampled only while `imem_req` is high.
- `imem_data`  in  32  instruction word.
- `alu_ip_0`  out  32  operand A register.
- `alu_ip_1`  out  32  operand B register.
- `alu_opcode`  out  3  ALU opcode.
- `alu_op_0`  in  32  ALU result.
- `alu_change_pc`  in  1  ALU branch-taken flag.
- `halted`  out  1  high while in HALT.
- `pc`  out  PC_W  current PC.
- `dbg_sel`  in  3  debug register select.
- `dbg_data`  out  32  combinational read of `R[dbg_sel]`; `R0` reads 0.

## Operation
- Instruction word fields: `[31:29]` opcode, `[28:26]` rd, `[25:23]` rs1, `[22:20]` rs2, `[19:0]` imm.
- Opcodes:
  - 000 LDI: `R[rd] <= zext(imm)`.
  - 001 HALT.
  - 010 BEQ, 011 BLT: branch if `alu_change_pc`.
  - 100 ADD, 101 SUB, 110 AND, 111 OR: `R[rd] <= alu_op_0`.
- `R0` is hardwired to zero; writes to it are discarded.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
  - IDLE → FETCH unconditionally.
  - FETCH: when `imem_req && imem_valid`, capture `IR <= imem_data` and go to DECODE; otherwise stay in FETCH.
  - DECODE: `A <= R[rs1]`, `B <= R[rs2]`; go to EXECUTE.
  - EXECUTE: `alu_opcode = IR[31:29]`; latch `res <= alu_op_0` and `tk <= alu_change_pc`; go to WRITEBACK. HALT decodes here: go to HALT, PC unchanged.
  - WRITEBACK:
    - Register write per opcode.
    - `PC <= tk ? PC + sext(imm[PC_W-1:0]) : PC + 1` for BEQ/BLT.
    - `PC <= PC + 1` for all other opcodes.
    - Go to FETCH.
  - HALT: remain there until `rst`.
- `alu_opcode` is 3'b000 outside EXECUTE. The ALU result is sampled only in EXECUTE.
- `alu_ip_0 = A`, `alu_ip_1 = B` at all times.
- PC arithmetic is modulo 2^PC_W. Wrap from max to 0 is legal.
- A branch with `imm = 0` that is taken loops on itself.

## Timing
- Reset values:
  - State IDLE, PC 0, IR 0, A/B/res 0, tk 0, all registers 0.
  - `imem_req` 0, `alu_opcode` 0, `halted` 0.
- `rst` wins over every state, including mid-FETCH or with `imem_valid` high. An instruction in flight is abandoned with no register or PC write.
- `imem_req` first rises 2 cycles after the `rst` edge: IDLE, then FETCH.
- FETCH lasts at least 1 cycle. `imem_valid` may arrive in the first FETCH cycle.
- CPI = FETCH cycles + 3 (DECODE, EXECUTE, WRITEBACK), so 4 with zero-wait memory.
- A register written in WRITEBACK is visible to the next instruction's DECODE. No hazards exist.
- `dbg_data` reflects a write on the cycle after the WRITEBACK edge.
- `imem_data` is ignored except on the capture edge. `imem_valid` while not requesting is ignored.

## Configuration
- `MC_SEQ_PERF_EN`, when defined, adds two outputs:
  - `perf_cycles [31:0]`: increments every non-reset cycle, including in HALT.
  - `perf_retired [31:0]`: increments once per WRITEBACK.
  - Both reset to 0 and wrap at 2^32.
- Without `MC_SEQ_PERF_EN`, these ports and their counters do not exist.

## Test plan
- Zero-wait memory, program `LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT` → `R3 = 8`; `halted` rises at cycle 16 after reset release; `pc = 3`.
- `SUB r4,r1,r2` then `AND`/`OR` with `r1 = 0xC`, `r2 = 0xA` → `R4 = 2`, AND = 0x8, OR = 0xE; `alu_opcode` is 101/110/111 only in EXECUTE.
- `BEQ r1,r1,imm=4` at PC 2 → next fetch address 6. `BLT r2,r1` with `r2 = 3`, `r1 = 5`, `imm = 0xFFFFF` at PC 6 → next fetch address 5. Not-taken case → PC + 1.
- Hold `imem_valid` low for 5 FETCH cycles → `imem_req` stays high throughout; IR and PC are unchanged until `valid` arrives.
- Assert `rst` during EXECUTE of `ADD r3` → `R3` stays 0, PC returns to 0, `imem_req` is low for 2 cycles.
- `LDI r0,7` → `dbg_data(sel = 0) = 0`. With `MC_SEQ_PERF_EN`, after the first program `perf_retired = 3`.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: fetches instructions, reads an 8x32 register file,
// drives the ALU and writes back results. Optional perf counters via MC_SEQ_PERF_EN.
module mc_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_data,
    output logic [31:0]     alu_ip_0,
    output logic [31:0]     alu_ip_1,
    output logic [2:0]      alu_opcode,
    input  logic [31:0]     alu_op_0,
    input  logic            alu_change_pc,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    input  logic [2:0]      dbg_sel,
    output logic [31:0]     dbg_data
`ifdef MC_SEQ_PERF_EN
   ,output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_retired
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    localparam logic [2:0] OP_LDI  = 3'b000;
    localparam logic [2:0] OP_HALT = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BLT  = 3'b011;

    state_t            state_r, state_s;
    logic [PC_W-1:0]   pc_r;
    logic [31:0]       ir_r, a_r, b_r, res_r;
    logic              tk_r;
    logic [31:0]       rf_r [0:7];
    logic              imem_req_r, halted_r;
    logic [2:0]        alu_opcode_r;

    logic [2:0]        op_s, rd_s, rs1_s, rs2_s;
    logic [19:0]       imm_s;
    logic [PC_W-1:0]   pc_next_s, branch_tgt_s;

    // R0 always reads as zero regardless of storage contents
    function automatic logic [31:0] reg_read(input logic [2:0] sel);
        return (sel == 3'd0) ? 32'd0 : rf_r[sel];
    endfunction

    assign op_s   = ir_r[31:29];
    assign rd_s   = ir_r[28:26];
    assign rs1_s  = ir_r[25:23];
    assign rs2_s  = ir_r[22:20];
    assign imm_s  = ir_r[19:0];

    // Sign extension of imm[PC_W-1:0] to PC_W bits is the identity, so modulo add suffices
    assign pc_next_s    = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    assign branch_tgt_s = pc_r + imm_s[PC_W-1:0];

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign halted     = halted_r;
    assign alu_opcode = alu_opcode_r;
    assign alu_ip_0   = a_r;
    assign alu_ip_1   = b_r;
    assign dbg_data   = reg_read(dbg_sel);

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:      state_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_req_r && imem_valid) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE:    state_s = ST_EXECUTE;
            ST_EXECUTE: begin
                if (op_s == OP_HALT) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: state_s = ST_FETCH;
            ST_HALT:      state_s = ST_HALT;
            default:      state_s = ST_IDLE;
        endcase
    end

    // State, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= '0;
            ir_r         <= 32'd0;
            a_r          <= 32'd0;
            b_r          <= 32'd0;
            res_r        <= 32'd0;
            tk_r         <= 1'b0;
            imem_req_r   <= 1'b0;
            halted_r     <= 1'b0;
            alu_opcode_r <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else begin
            state_r      <= state_s;
            imem_req_r   <= (state_s == ST_FETCH);
            halted_r     <= (state_s == ST_HALT);
            alu_opcode_r <= (state_s == ST_EXECUTE) ? ir_r[31:29] : 3'd0;
            case (state_r)
                ST_FETCH: begin
                    if (imem_req_r && imem_valid) begin
                        ir_r <= imem_data;
                    end
                end
                ST_DECODE: begin
                    a_r <= reg_read(rs1_s);
                    b_r <= reg_read(rs2_s);
                end
                ST_EXECUTE: begin
                    res_r <= alu_op_0;
                    tk_r  <= alu_change_pc;
                end
                ST_WRITEBACK: begin
                    if (rd_s != 3'd0) begin
                        if (op_s == OP_LDI) begin
                            rf_r[rd_s] <= {12'd0, imm_s};
                        end else if (op_s[2]) begin
                            rf_r[rd_s] <= res_r;
                        end
                    end
                    if ((op_s == OP_BEQ) || (op_s == OP_BLT)) begin
                        pc_r <= tk_r ? branch_tgt_s : pc_next_s;
                    end else begin
                        pc_r <= pc_next_s;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MC_SEQ_PERF_EN
    logic [31:0] perf_cycles_r, perf_retired_r;

    assign perf_cycles  = perf_cycles_r;
    assign perf_retired = perf_retired_r;

    // Free-running cycle and retirement counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_r  <= 32'd0;
            perf_retired_r <= 32'd0;
        end else begin
            perf_cycles_r <= perf_cycles_r + 32'd1;
            if (state_r == ST_WRITEBACK) begin
                perf_retired_r <= perf_retired_r + 32'd1;
            end
        end
    end
`endif

endmodule
